// File: rtl/genie_merge_rr_if.sv
// NI-to-1 merge stream bundle: NI upstream valid/ready lanes plus one registered downstream lane.
// The slave modport is the merge block's view; master is the traffic source/sink view.
interface genie_merge_rr_if #(
  parameter int NI    = 2,
  parameter int WIDTH = 8
);
  logic [NI*WIDTH-1:0] i_data;
  logic [NI-1:0]       i_valid;
  logic [NI-1:0]       i_eop;
  logic [NI-1:0]       o_ready;
  logic [WIDTH-1:0]    o_data;
  logic                o_valid;
  logic                o_eop;
  logic                i_ready;

  modport master (
    output i_data, i_valid, i_eop, i_ready,
    input  o_ready, o_data, o_valid, o_eop
  );

  modport slave (
    input  i_data, i_valid, i_eop, i_ready,
    output o_ready, o_data, o_valid, o_eop
  );
endinterface

// File: rtl/genie_merge_rr.sv
// Round-robin packet-locking NI-to-1 merge into a registered output; a beat accepted on edge n is visible after edge n.
// Full throughput with i_ready high; while the held beat is stalled all o_ready are low and the output holds.
module genie_merge_rr #(
  parameter int NI    = 2,
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  genie_merge_rr_if.slave bus
);
  localparam int PW = (NI > 1) ? $clog2(NI) : 1;

  typedef enum logic {IDLE, LOCKED} mode_t;

  mode_t            mode_q, mode_d;
  logic [PW-1:0]    sel_q, sel_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gnt, cur;
  logic             gnt_vld;
  logic             load;
  logic             xfer;
  logic [NI-1:0]    ready;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             eop_q;

  // Explicit wrap: NI need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (x == PW'(NI - 1)) ? '0 : x + PW'(1);
  endfunction

  assign load = !valid_q || bus.i_ready;

  // Lowest offset from ptr wins; scanning downward lets the nearest valid input overwrite the others.
  always_comb begin : arb
    logic [PW-1:0] k;
    k       = '0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = NI - 1; i >= 0; i--) begin
      k = PW'((int'(ptr_q) + i) % NI);
      if (bus.i_valid[k]) begin
        gnt_vld = 1'b1;
        gnt     = k;
      end
    end
  end

  always_comb begin : fsm
    mode_d = mode_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    ready  = '0;
    xfer   = 1'b0;
    cur    = gnt;
    case (mode_q)
      IDLE: begin
        if (gnt_vld && load) begin
          ready[gnt] = 1'b1;
          xfer       = 1'b1;
          if (bus.i_eop[gnt]) begin
            ptr_d = wrap_inc(gnt);
          end else begin
            mode_d = LOCKED;
            sel_d  = gnt;
          end
        end
      end
      LOCKED: begin
        cur = sel_q;
        if (load) begin
          ready[sel_q] = 1'b1;
          if (bus.i_valid[sel_q]) begin
            xfer = 1'b1;
            if (bus.i_eop[sel_q]) begin
              mode_d = IDLE;
              ptr_d  = wrap_inc(sel_q);
            end
          end
        end
      end
      default: mode_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_q <= IDLE;
      sel_q  <= '0;
      ptr_q  <= '0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= xfer;
      if (xfer) begin
        data_q <= bus.i_data[cur*WIDTH +: WIDTH];
        eop_q  <= bus.i_eop[cur];
      end
    end
  end

  // The next-state logic sees reset-state registers, but o_ready must also be quiet during reset.
  assign bus.o_ready = i_reset ? '0 : ready;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_eop   = eop_q;
endmodule
